// File: rtl/recon_pkg.sv
// Shared types and default constants for the modulo-ADC reconstruction sequencer.
package recon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } recon_state_t;

    localparam logic [23:0] LAMBDA_DEFAULT = 24'h00C000;
    localparam int unsigned PIPE_LATENCY   = 45;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: latches the divide ratio at run start, emits a registered
// one-cycle tick every div_l clocks while active.
module sample_tick_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             active,
    input  logic             abort,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             tick,
    output logic             tick_pulse
);

    logic [DIV_W-1:0] div_l_q;
    logic [DIV_W-1:0] cnt_q;
    logic             tick_q;

    assign tick       = active && (cnt_q == div_l_q - DIV_W'(1));
    assign tick_pulse = tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_l_q <= DIV_W'(2);
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            // A ratio below 2 would collapse the tick into a constant enable.
            if (load) begin
                div_l_q <= (div_cfg < DIV_W'(2)) ? DIV_W'(2) : div_cfg;
            end
            if (load || !active || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
            tick_q <= tick && !abort;
        end
    end

endmodule

// File: rtl/recon_sequencer.sv
// Reconstruction pipeline sequencer: fill/run/drain control, sample-tick strobes
// and the idle-only LAMBDA update path.
module recon_sequencer #(
    parameter int unsigned      WIDTH           = 24,
    parameter int unsigned      FRACTIONAL_BITS = 16,
    parameter logic [WIDTH-1:0] LAMBDA_DEFAULT  = WIDTH'(recon_pkg::LAMBDA_DEFAULT),
    parameter int unsigned      PIPE_LATENCY    = recon_pkg::PIPE_LATENCY,
    parameter int unsigned      DIV_W           = 16,
    parameter int unsigned      CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_lambda,
    output logic             pipe_clk_en,
    output logic             pipe_start,
    output logic [WIDTH-1:0] lambda_o,
    output logic             dac_valid,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic             done,
    output logic [CNT_W-1:0] sample_count
);
    import recon_pkg::*;

    localparam int unsigned FILL_W = $clog2(PIPE_LATENCY + 1);

    if (FRACTIONAL_BITS >= WIDTH) begin : g_frac_check
        $error("FRACTIONAL_BITS must be smaller than WIDTH");
    end

    recon_state_t      state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              stop_pend_q, stop_pend_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  shadow_q, lambda_q;
    logic              tick, launch, abort;

    sample_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .load       (launch),
        .active     (state_q != IDLE),
        .abort      (abort),
        .div_cfg    (div_cfg),
        .tick       (tick),
        .tick_pulse (pipe_clk_en)
    );

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        start_d     = 1'b0;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        launch      = 1'b0;
        abort       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_req && !stop_req) begin
                    state_d     = PRIME;
                    launch      = 1'b1;
                    fill_d      = '0;
                    count_d     = '0;
                    stop_pend_d = 1'b0;
                end
            end
            PRIME: begin
                if (stop_req) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (tick) begin
                    start_d = 1'b1;
                    fill_d  = fill_q + FILL_W'(1);
                    if (fill_d == FILL_W'(PIPE_LATENCY)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                stop_pend_d = stop_pend_q | stop_req;
                if (tick) begin
                    valid_d = 1'b1;
                    if (stop_pend_d) begin
                        // The transition tick is the first of the drain outputs.
                        stop_pend_d = 1'b0;
                        fill_d      = FILL_W'(1);
                        if (PIPE_LATENCY <= 1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        start_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (tick) begin
                    valid_d = 1'b1;
                    fill_d  = fill_q + FILL_W'(1);
                    if (fill_d == FILL_W'(PIPE_LATENCY)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (valid_d && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            shadow_q    <= LAMBDA_DEFAULT;
            lambda_q    <= LAMBDA_DEFAULT;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            if (cfg_wr) begin
                shadow_q <= cfg_lambda;
            end
            // Active LAMBDA only follows the shadow while idle.
            if (state_q == IDLE) begin
                lambda_q <= shadow_q;
            end
        end
    end

    assign pipe_start   = start_q;
    assign dac_valid    = valid_q;
    assign done         = done_q;
    assign lambda_o     = lambda_q;
    assign busy         = (state_q != IDLE);
    assign state_o      = state_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_recon_sequencer.sv
// Self-checking bench for recon_sequencer: tick-indexed model of fill/run/drain runs.
module tb_recon_sequencer;

    localparam int PL    = 3;
    localparam int WIDTH = 24;
    localparam int DIV_W = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             run_req;
    logic             stop_req;
    logic [DIV_W-1:0] div_cfg;
    logic             cfg_wr;
    logic [WIDTH-1:0] cfg_lambda;
    logic             pipe_clk_en;
    logic             pipe_start;
    logic [WIDTH-1:0] lambda_o;
    logic             dac_valid;
    logic             busy;
    logic [1:0]       state_o;
    logic             done;
    logic [CNT_W-1:0] sample_count;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] lam_model;

    always #5 clk = ~clk;

    recon_sequencer #(
        .WIDTH           (WIDTH),
        .FRACTIONAL_BITS (16),
        .LAMBDA_DEFAULT  (24'h00C000),
        .PIPE_LATENCY    (PL),
        .DIV_W           (DIV_W),
        .CNT_W           (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run_req      (run_req),
        .stop_req     (stop_req),
        .div_cfg      (div_cfg),
        .cfg_wr       (cfg_wr),
        .cfg_lambda   (cfg_lambda),
        .pipe_clk_en  (pipe_clk_en),
        .pipe_start   (pipe_start),
        .lambda_o     (lambda_o),
        .dac_valid    (dac_valid),
        .busy         (busy),
        .state_o      (state_o),
        .done         (done),
        .sample_count (sample_count)
    );

    // Full run: fill PL ticks, n_run RUN ticks, stop, drain PL ticks; every cycle checked.
    task automatic run_seq(input int dcfg, input int n_run, input bit do_wr,
                           input logic [WIDTH-1:0] wr_val);
        int d, total, p, p_eff, sc;
        bit on;
        logic [4:0] exp_ctrl;
        logic [1:0] exp_state;
        logic [WIDTH-1:0] exp_lam;
        d     = (dcfg < 2) ? 2 : dcfg;
        total = 2 * PL + n_run;
        @(negedge clk);
        run_req = 1'b1;
        div_cfg = DIV_W'(dcfg);
        @(negedge clk);
        run_req = 1'b0;
        for (int k = 0; k <= total * d + 2; k++) begin
            p     = k / d;
            p_eff = (p > total) ? total : p;
            on    = (k > 0) && (k % d == 0) && (p <= total);
            if (p_eff < PL)              exp_state = 2'd1;
            else if (p_eff < PL + n_run + 1) exp_state = 2'd2;
            else if (p_eff < total)      exp_state = 2'd3;
            else                         exp_state = 2'd0;
            sc       = (p_eff > PL) ? p_eff - PL : 0;
            exp_ctrl = {on, on && (p <= PL + n_run), on && (p > PL), on && (p == total),
                        exp_state != 2'd0};
            exp_lam  = (do_wr && k > total * d) ? wr_val : lam_model;
            n_cmp++;
            if ({pipe_clk_en, pipe_start, dac_valid, done, busy} !== exp_ctrl) begin
                n_bad++;
                $display("FAIL ctrl d=%0d k=%0d: got en/start/valid/done/busy=%b want %b",
                         d, k, {pipe_clk_en, pipe_start, dac_valid, done, busy}, exp_ctrl);
            end
            n_cmp++;
            if (state_o !== exp_state) begin
                n_bad++;
                $display("FAIL state d=%0d k=%0d: got %0d want %0d", d, k, state_o, exp_state);
            end
            n_cmp++;
            if (sample_count !== CNT_W'(sc)) begin
                n_bad++;
                $display("FAIL sample_count d=%0d k=%0d: got %0d want %0d",
                         d, k, sample_count, sc);
            end
            n_cmp++;
            if (lambda_o !== exp_lam) begin
                n_bad++;
                $display("FAIL lambda d=%0d k=%0d: got %h want %h", d, k, lambda_o, exp_lam);
            end
            // Latched ratio must ignore later div_cfg changes; run_req while busy is ignored.
            div_cfg    = DIV_W'($urandom_range(0, 9));
            run_req    = (k < total * d) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop_req   = (k == (PL + n_run) * d) ||
                         (k >= (PL + n_run + 1) * d && k < total * d &&
                          $urandom_range(0, 1) == 1);
            cfg_wr     = do_wr && (k == PL * d + 1);
            cfg_lambda = wr_val;
            @(negedge clk);
        end
        run_req  = 1'b0;
        stop_req = 1'b0;
        cfg_wr   = 1'b0;
        if (do_wr) lam_model = wr_val;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({pipe_clk_en, pipe_start, dac_valid, done, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {pipe_clk_en, pipe_start, dac_valid, done, busy});
        end
        n_cmp++;
        if (state_o !== 2'd0 || sample_count !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got state=%0d count=%0d want 0/0", state_o, sample_count);
        end
        n_cmp++;
        if (lambda_o !== 24'h00C000) begin
            n_bad++;
            $display("FAIL reset_lambda: got %h want 00c000", lambda_o);
        end
        reset     = 1'b0;
        lam_model = 24'h00C000;
        @(negedge clk);
    endtask

    task automatic test_fill_and_drain();
        run_seq(4, 5, 1'b0, '0);
    endtask

    task automatic test_div_min();
        run_seq(0, 2, 1'b0, '0);
        run_seq(1, 1, 1'b0, '0);
        run_seq(7, 0, 1'b0, '0);
    endtask

    task automatic test_lambda_busy();
        run_seq(4, 2, 1'b1, 24'h008000);
    endtask

    task automatic test_lambda_idle(input logic [WIDTH-1:0] v);
        cfg_wr     = 1'b1;
        cfg_lambda = v;
        @(negedge clk);
        cfg_wr = 1'b0;
        n_cmp++;
        if (lambda_o !== lam_model) begin
            n_bad++;
            $display("FAIL lambda_idle_1: got %h want %h", lambda_o, lam_model);
        end
        @(negedge clk);
        n_cmp++;
        if (lambda_o !== v) begin
            n_bad++;
            $display("FAIL lambda_idle_2: got %h want %h", lambda_o, v);
        end
        lam_model = v;
    endtask

    task automatic test_prime_abort(input int d);
        run_req = 1'b1;
        div_cfg = DIV_W'(d);
        @(negedge clk);
        run_req = 1'b0;
        for (int k = 0; k <= 3 * d; k++) begin
            n_cmp++;
            if ({pipe_clk_en, pipe_start, dac_valid, done, busy} !==
                {k == d, k == d, 1'b0, 1'b0, k <= d}) begin
                n_bad++;
                $display("FAIL prime_abort k=%0d: got %b", k,
                         {pipe_clk_en, pipe_start, dac_valid, done, busy});
            end
            n_cmp++;
            if (state_o !== ((k <= d) ? 2'd1 : 2'd0)) begin
                n_bad++;
                $display("FAIL prime_abort_state k=%0d: got %0d", k, state_o);
            end
            stop_req = (k == d);
            @(negedge clk);
        end
        stop_req = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_seq(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), WIDTH'($urandom));
        end
    endtask

    task automatic test_reset_mid_drain();
        run_req = 1'b1;
        div_cfg = 16'd4;
        @(negedge clk);
        run_req = 1'b0;
        for (int k = 0; k < (PL + 2) * 4 + 1; k++) begin
            stop_req = (k == (PL + 1) * 4);
            @(negedge clk);
        end
        stop_req = 1'b0;
        n_cmp++;
        if (state_o !== 2'd3) begin
            n_bad++;
            $display("FAIL mid_drain_precond: got state %0d want 3", state_o);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({pipe_clk_en, pipe_start, dac_valid, done, busy, state_o} !== 7'b0 ||
            sample_count !== '0 || lambda_o !== 24'h00C000) begin
            n_bad++;
            $display("FAIL mid_drain_reset: got ctrl=%b state=%0d count=%0d lambda=%h",
                     {pipe_clk_en, pipe_start, dac_valid, done, busy}, state_o,
                     sample_count, lambda_o);
        end
        lam_model = 24'h00C000;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({pipe_clk_en, dac_valid, done, state_o} !== 5'b0) begin
                n_bad++;
                $display("FAIL post_reset k=%0d: got en/valid/done=%b state=%0d",
                         k, {pipe_clk_en, dac_valid, done}, state_o);
            end
        end
    endtask

    task automatic test_run_stop_same();
        run_req  = 1'b1;
        stop_req = 1'b1;
        div_cfg  = 16'd2;
        @(negedge clk);
        run_req  = 1'b0;
        stop_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (state_o !== 2'd0 || busy !== 1'b0 || pipe_clk_en !== 1'b0) begin
                n_bad++;
                $display("FAIL run_stop_same k=%0d: got state=%0d busy=%b en=%b",
                         k, state_o, busy, pipe_clk_en);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        run_req    = 1'b0;
        stop_req   = 1'b0;
        div_cfg    = '0;
        cfg_wr     = 1'b0;
        cfg_lambda = '0;
        lam_model  = 24'h00C000;
        test_reset();
        test_fill_and_drain();
        test_div_min();
        test_lambda_busy();
        test_lambda_idle(24'h00A000);
        test_prime_abort(4);
        test_random();
        test_reset_mid_drain();
        test_run_stop_same();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
